// File: rtl/goertzel_pkg.sv
// rtl/goertzel_pkg.sv - shared constants and state types for the Goertzel tone detector
package goertzel_pkg;

    localparam int MAG_W     = 40;
    localparam int BLOCK_LEN = 205;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        WAIT,
        CAPTURE,
        CLEAR
    } seq_state_t;

    typedef enum logic {
        ABSENT,
        PRESENT
    } det_state_t;

endpackage

// File: rtl/tone_hysteresis.sv
// rtl/tone_hysteresis.sv - on/off threshold hysteresis with consecutive-block debounce
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   eval            one-cycle strobe: judge value against the thresholds
//   value           magnitude under test (unsigned)
//   thr_on          detection threshold, value >= thr_on is a hit
//   thr_off         release threshold, value < thr_off is a miss
//   present         registered detection state
//   start_evt       one-cycle pulse on absent->present
//   end_evt         one-cycle pulse on present->absent
module tone_hysteresis #(
    parameter int W       = 40,
    parameter int CONFIRM = 3,
    parameter int RELEASE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         eval,
    input  logic [W-1:0] value,
    input  logic [W-1:0] thr_on,
    input  logic [W-1:0] thr_off,
    output logic         present,
    output logic         start_evt,
    output logic         end_evt
);
    import goertzel_pkg::*;

    localparam int CNT_MAX = (CONFIRM > RELEASE) ? CONFIRM : RELEASE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    det_state_t       state, state_d;
    logic [CNT_W-1:0] hit_cnt, hit_d;
    logic [CNT_W-1:0] miss_cnt, miss_d;
    logic             start_d, end_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ABSENT;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            start_evt <= 1'b0;
            end_evt   <= 1'b0;
        end else begin
            state     <= state_d;
            hit_cnt   <= hit_d;
            miss_cnt  <= miss_d;
            start_evt <= start_d;
            end_evt   <= end_d;
        end
    end

    // The counters never pass CONFIRM-1 / RELEASE-1: reaching the limit
    // changes state and clears them in the same evaluation.
    always_comb begin
        state_d = state;
        hit_d   = hit_cnt;
        miss_d  = miss_cnt;
        start_d = 1'b0;
        end_d   = 1'b0;
        if (eval) begin
            case (state)
                ABSENT: begin
                    if (value >= thr_on) begin
                        if (hit_cnt >= CNT_W'(CONFIRM - 1)) begin
                            state_d = PRESENT;
                            hit_d   = '0;
                            miss_d  = '0;
                            start_d = 1'b1;
                        end else begin
                            hit_d = hit_cnt + CNT_W'(1);
                        end
                    end else begin
                        hit_d = '0;
                    end
                end
                PRESENT: begin
                    if (value < thr_off) begin
                        if (miss_cnt >= CNT_W'(RELEASE - 1)) begin
                            state_d = ABSENT;
                            miss_d  = '0;
                            hit_d   = '0;
                            end_d   = 1'b1;
                        end else begin
                            miss_d = miss_cnt + CNT_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = ABSENT;
            endcase
        end
    end

    assign present = (state == PRESENT);

endmodule

// File: rtl/goertzel_tone_detector.sv
// rtl/goertzel_tone_detector.sv - block framing, magnitude capture and tone decision for goertzel_filter
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              run enable; low returns the sequencer to IDLE
//   magnitude       filter magnitude input
//   thr_on/thr_off  unsigned detect / release thresholds
//   blk_clr         filter clear (high in IDLE and for one cycle per block)
//   mag_valid       one-cycle capture strobe
//   mag_hold        magnitude captured at the last block end
//   tone_present    debounced detection state
//   tone_start      pulse on absent->present
//   tone_end        pulse on present->absent
//   blk_cnt         sample index within the current block
module goertzel_tone_detector #(
    parameter int MAG_W     = goertzel_pkg::MAG_W,
    parameter int BLOCK_LEN = goertzel_pkg::BLOCK_LEN,
    parameter int MAG_LAT   = 1,
    parameter int CONFIRM   = 3,
    parameter int RELEASE   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [MAG_W-1:0]             magnitude,
    input  logic [MAG_W-1:0]             thr_on,
    input  logic [MAG_W-1:0]             thr_off,
    output logic                         blk_clr,
    output logic                         mag_valid,
    output logic [MAG_W-1:0]             mag_hold,
    output logic                         tone_present,
    output logic                         tone_start,
    output logic                         tone_end,
    output logic [$clog2(BLOCK_LEN)-1:0] blk_cnt
);
    import goertzel_pkg::*;

    localparam int            BW   = $clog2(BLOCK_LEN);
    localparam logic [BW-1:0] LAST = BW'(BLOCK_LEN - 1);

    seq_state_t state, state_d;
    logic [1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        blk_clr   = 1'b0;
        mag_valid = 1'b0;
        case (state)
            IDLE: begin
                blk_clr = 1'b1;
                if (en) state_d = ACCUM;
            end
            ACCUM: begin
                if (blk_cnt == LAST) state_d = (MAG_LAT == 0) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'(MAG_LAT - 1)) state_d = CAPTURE;
            end
            CAPTURE: begin
                mag_valid = 1'b1;
                state_d   = CLEAR;
            end
            CLEAR: begin
                blk_clr = 1'b1;
                state_d = ACCUM;
            end
            default: state_d = IDLE;
        endcase
        // Dropping en abandons the partial block; the filter is held clear.
        if (!en) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt  <= '0;
            wait_cnt <= '0;
            mag_hold <= '0;
        end else begin
            if (!en || state == IDLE || state == CLEAR) begin
                blk_cnt <= '0;
            end else if (state == ACCUM && blk_cnt != LAST) begin
                blk_cnt <= blk_cnt + BW'(1);
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (state == CAPTURE) mag_hold <= magnitude;
        end
    end

    // The detector judges the value as it is being captured, so its
    // registered outputs appear in the cycle right after mag_valid, together
    // with the refreshed mag_hold they describe.
    tone_hysteresis #(
        .W       (MAG_W),
        .CONFIRM (CONFIRM),
        .RELEASE (RELEASE)
    ) u_hyst (
        .clk       (clk),
        .rst       (rst),
        .eval      (mag_valid),
        .value     (magnitude),
        .thr_on    (thr_on),
        .thr_off   (thr_off),
        .present   (tone_present),
        .start_evt (tone_start),
        .end_evt   (tone_end)
    );

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// tb/tb_goertzel_tone_detector.sv - scoreboard bench for goertzel_tone_detector
module tb_goertzel_tone_detector;

    localparam int MW = 40;
    localparam int BL = 8;
    localparam int ML = 1;
    localparam int CF = 3;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [MW-1:0] magnitude;
    logic [MW-1:0] thr_on;
    logic [MW-1:0] thr_off;
    logic          blk_clr;
    logic          mag_valid;
    logic [MW-1:0] mag_hold;
    logic          tone_present;
    logic          tone_start;
    logic          tone_end;
    logic [2:0]    blk_cnt;

    goertzel_tone_detector #(
        .MAG_W     (MW),
        .BLOCK_LEN (BL),
        .MAG_LAT   (ML),
        .CONFIRM   (CF),
        .RELEASE   (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .magnitude    (magnitude),
        .thr_on       (thr_on),
        .thr_off      (thr_off),
        .blk_clr      (blk_clr),
        .mag_valid    (mag_valid),
        .mag_hold     (mag_hold),
        .tone_present (tone_present),
        .tone_start   (tone_start),
        .tone_end     (tone_end),
        .blk_cnt      (blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] mag;
        logic          present;
        logic          start;
        logic          stop;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic m_present = 1'b0;
    int   m_hit = 0;
    int   m_miss = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Reference model of the debounce: count first, then compare to the limit.
    function automatic void push_block(input logic [MW-1:0] m);
        exp_t e;
        e.mag   = m;
        e.start = 1'b0;
        e.stop  = 1'b0;
        if (!m_present) begin
            if (m >= thr_on) begin
                m_hit++;
                if (m_hit == CF) begin
                    m_present = 1'b1;
                    m_hit     = 0;
                    e.start   = 1'b1;
                end
            end else begin
                m_hit = 0;
            end
        end else begin
            if (m < thr_off) begin
                m_miss++;
                if (m_miss == RL) begin
                    m_present = 1'b0;
                    m_miss    = 0;
                    e.stop    = 1'b1;
                end
            end else begin
                m_miss = 0;
            end
        end
        e.present = m_present;
        exp_q.push_back(e);
    endfunction

    task automatic do_block(input logic [MW-1:0] m, input int exp_cyc);
        int n = 0;
        magnitude = m;
        push_block(m);
        while (!mag_valid && n < 40) begin
            tick();
            n++;
        end
        if (!mag_valid) begin
            chk("mv_timeout", mag_valid, 1);
            void'(exp_q.pop_back());
        end else begin
            if (exp_cyc >= 0) chk("mv_cycle", cyc, exp_cyc);
            tick();
        end
    endtask

    task automatic start_run();
        en  = 1'b1;
        rst = 1'b0;
        cyc = -1;
        tick();
        chk("clr_fall", blk_clr, 0);
        chk("cnt_start", blk_cnt, 0);
    endtask

    task automatic wait_cnt_at(input logic [2:0] target);
        int n = 0;
        while (!(blk_cnt == target && !blk_clr) && n < 40) begin
            tick();
            n++;
        end
        chk("reach_blk_cnt", blk_cnt, target);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("mag_hold", mag_hold, e.mag);
                chk("tone_present", tone_present, e.present);
                chk("tone_start", tone_start, e.start);
                chk("tone_end", tone_end, e.stop);
                chk("clr_after_valid", blk_clr, 1);
            end
        end else begin
            if (tone_start) chk("stray_start", tone_start, 0);
            if (tone_end) chk("stray_end", tone_end, 0);
        end
        prev_valid = mag_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        magnitude = '0;
        thr_on    = 500;
        thr_off   = 300;
        repeat (3) tick();
        chk("rst_blk_clr", blk_clr, 1);
        chk("rst_mag_valid", mag_valid, 0);
        chk("rst_mag_hold", mag_hold, 0);
        chk("rst_present", tone_present, 0);
        chk("rst_start", tone_start, 0);
        chk("rst_end", tone_end, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_clr", blk_clr, 1);
        chk("idle_cnt", blk_cnt, 0);

        // Steady tone: start on the third block, fixed block cadence.
        start_run();
        do_block(1000, 9);
        do_block(1000, 20);
        do_block(1000, 31);

        // Equal to thr_off is not a miss; just below it releases after two.
        repeat (4) do_block(300, -1);
        repeat (2) do_block(299, -1);

        // Alternating hits and misses never confirm.
        for (int i = 0; i < 3; i++) begin
            do_block(600, -1);
            do_block(400, -1);
        end

        // Equal to thr_on counts as a hit.
        repeat (3) do_block(500, -1);

        // Inverted thresholds are applied literally.
        thr_off = 800;
        repeat (2) do_block(700, -1);
        thr_off = 300;

        // en drop mid-block while present, with one miss already counted.
        repeat (3) do_block(1000, -1);
        do_block(100, -1);
        wait_cnt_at(3'd4);
        en = 1'b0;
        tick();
        chk("drop_clr", blk_clr, 1);
        chk("drop_cnt", blk_cnt, 0);
        chk("drop_present", tone_present, m_present);
        repeat (12) begin
            tick();
            chk("drop_no_valid", mag_valid, 0);
        end
        chk("drop_hold_present", tone_present, m_present);
        start_run();
        do_block(100, 9);

        // Asynchronous reset mid-block while present.
        repeat (3) do_block(1000, -1);
        wait_cnt_at(3'd5);
        rst = 1'b1;
        #1;
        chk("arst_present", tone_present, 0);
        chk("arst_start", tone_start, 0);
        chk("arst_end", tone_end, 0);
        chk("arst_clr", blk_clr, 1);
        chk("arst_valid", mag_valid, 0);
        chk("arst_hold", mag_hold, 0);
        chk("arst_cnt", blk_cnt, 0);
        m_present = 1'b0;
        m_hit     = 0;
        m_miss    = 0;
        repeat (2) tick();
        start_run();
        do_block(1000, 9);
        do_block(1000, 20);
        do_block(1000, 31);

        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/goertzel_tone_detector.md
Name: goertzel_tone_detector

Overview:
Downstream control and decision stage for goertzel_filter. Frames the free-running filter into fixed-length analysis blocks: it drives the filter's clear, captures the 40-bit magnitude at each block end, and applies an on/off threshold with hysteresis plus consecutive-block debouncing. It reports tone presence and start/end events to the system controller.

Parameters:
MAG_W, 40, magnitude width; matches the filter output.
BLOCK_LEN, 205, samples (clk cycles) per analysis block; must be ≥2.
MAG_LAT, 1, cycles from the last accumulated sample to a valid filter magnitude; range 0..3.
CONFIRM, 3, consecutive blocks at or above thr_on needed to declare a tone; must be ≥1.
RELEASE, 2, consecutive blocks below thr_off needed to drop a tone; must be ≥1.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
en  in  1  run enable; low forces the idle state.
magnitude  in  MAG_W  magnitude from goertzel_filter.
thr_on  in  MAG_W  unsigned detection threshold.
thr_off  in  MAG_W  unsigned release threshold; nominally ≤ thr_on.
blk_clr  out  1  clear to the filter; the system ORs it with rst on the filter reset input.
mag_valid  out  1  one-cycle strobe; mag_hold updated.
mag_hold  out  MAG_W  magnitude captured at the last block end.
tone_present  out  1  debounced detection state.
tone_start  out  1  one-cycle pulse on the absent→present transition.
tone_end  out  1  one-cycle pulse on the present→absent transition.
blk_cnt  out  clog2(BLOCK_LEN)  sample index within the current block.

Behaviour:
- Reset values: blk_clr=1, all other outputs 0. The block sequencer and detector are in IDLE/ABSENT, and all counters are 0.
- Block sequencer states and transitions:
  - IDLE: blk_clr=1, blk_cnt=0. On en=1, go to ACCUM with blk_clr=0 in the next cycle.
  - ACCUM: blk_cnt increments once per clk. At blk_cnt==BLOCK_LEN-1, go to WAIT, or straight to CAPTURE if MAG_LAT==0.
  - WAIT: stays MAG_LAT cycles, then goes to CAPTURE.
  - CAPTURE: mag_hold<=magnitude and mag_valid=1 for exactly this cycle. Go to CLEAR.
  - CLEAR: blk_clr=1 for one cycle and blk_cnt<=0, then return to ACCUM.
  - Block period = BLOCK_LEN + MAG_LAT + 2 cycles.
- en low in any state: the next state is IDLE and blk_clr is asserted. No capture occurs for the partial block. The detector holds its state and counters and does not emit tone_end.
- Detector: evaluated only on the cycle after mag_valid, using mag_hold. Compares are unsigned over the full MAG_W.
  - ABSENT state: if mag_hold ≥ thr_on, hit_cnt++; otherwise hit_cnt<=0. When hit_cnt reaches CONFIRM, go to PRESENT, pulse tone_start, and clear hit_cnt.
  - PRESENT state: if mag_hold < thr_off, miss_cnt++; otherwise miss_cnt<=0. When miss_cnt reaches RELEASE, go to ABSENT, pulse tone_end, and clear miss_cnt.
  - tone_present is registered and equals state==PRESENT. It rises in the same cycle as the tone_start pulse and falls in the same cycle as the tone_end pulse.
- Boundary conditions:
  - mag_hold exactly equal to thr_on counts as a hit. mag_hold exactly equal to thr_off does not count as a miss.
  - thr_off > thr_on is not rejected; the rules above apply literally.
  - Threshold changes take effect at the next evaluation.
  - The hit and miss counters saturate and are sized clog2(max(CONFIRM,RELEASE)+1).
  - tone_start and tone_end never assert in the same cycle.
  - rst mid-block returns everything to reset values immediately. The first block after reset is full length.

Decomposition:
- Package goertzel_pkg holds MAG_W and the default BLOCK_LEN, plus two enums:
  - sequencer states: IDLE, ACCUM, WAIT, CAPTURE, CLEAR;
  - detector states: ABSENT, PRESENT.
- The sequencer stays in this module.
- The hysteresis/debounce logic becomes sub-module tone_hysteresis, with inputs eval strobe, value, thr_on, thr_off and outputs present, start, end.

Test Plan:
- Reset, then en=1 with BLOCK_LEN=8 and MAG_LAT=1 → blk_clr falls 1 cycle after en. mag_valid pulses at cycles 9, 20, 31 after en (period 11). blk_clr is high for one cycle immediately after each mag_valid.
- magnitude held at 1000, thr_on=500, thr_off=300, CONFIRM=3 → tone_start pulses once, one cycle after the 3rd mag_valid. tone_present stays 1 thereafter.
- From PRESENT, magnitude=300 (equal to thr_off) for 4 blocks → no tone_end. Then magnitude=299 for 2 blocks → tone_end one cycle after the 2nd mag_valid.
- magnitude alternates 600/400 per block with thr_on=500 → hit_cnt never reaches 3 and tone_present stays 0.
- en dropped at blk_cnt=4 → blk_clr=1 next cycle, no mag_valid, tone_present unchanged. Re-raising en gives a full 8-sample block.
- rst asserted at blk_cnt=5 while in PRESENT → all outputs reset asynchronously with no tone_end pulse. After release the sequence restarts as in the first scenario.
